// File: rtl/pipeline_exe_pkg.sv
// Shared encodings for the EXE-stage branch/result unit.
package pipeline_exe_pkg;

    // Branch funct3 encodings
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    // Fall-through PC steps
    localparam int STEP_RVC = 2;
    localparam int STEP_STD = 4;

    // Multi-cycle sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } exe_state_e;

endpackage

// File: rtl/branch_compare.sv
// Combinational branch condition evaluation selected by funct3.
module branch_compare
    import pipeline_exe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      br_op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken
);

    logic eq, lt, ltu;

    assign eq  = (rs1 == rs2);
    assign lt  = ($signed(rs1) < $signed(rs2));
    assign ltu = (rs1 < rs2);

    // Select the condition; reserved encodings resolve as not taken
    always_comb begin
        taken = 1'b0;
        case (br_op)
            BR_BEQ:  taken = eq;
            BR_BNE:  taken = !eq;
            BR_BLT:  taken = lt;
            BR_BGE:  taken = !lt;
            BR_BLTU: taken = ltu;
            BR_BGEU: taken = !ltu;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipeline_exe_bru.sv
// EXE-stage branch resolution, predictor update, multi-cycle sequencing
// and EX/MEM result staging.
module pipeline_exe_bru
    import pipeline_exe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RVC_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid_i,
    input  logic            is_branch_i,
    input  logic            is_jalr_i,
    input  logic            is_mc_i,
    input  logic            is_compressed_i,
    input  logic [2:0]      br_op_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic            pred_taken_i,
    input  logic [XLEN-1:0] pred_pc_i,
    input  logic            mc_done_i,
    input  logic [XLEN-1:0] mc_result_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            mc_start_o,
    output logic            mc_kill_o,
    output logic            stall_req_o,
    output logic            valid_e_o,
    output logic [XLEN-1:0] result_e_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            upd_valid_o,
    output logic            upd_taken_o,
    output logic [XLEN-1:0] upd_pc_o,
    output logic [XLEN-1:0] upd_target_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    logic [XLEN-1:0] step, seq, btgt, jtgt, rpc_n;
    logic            shadow, acc, taken, br_mis, jalr_mis, redir_n, upd_n;
    exe_state_e      state, state_n;
    logic            start_ok, mc_latch, ld_valid;
    logic [XLEN-1:0] ld_result, mc_hold_q;

    assign step = ((RVC_EN != 0) && is_compressed_i) ? XLEN'(STEP_RVC) : XLEN'(STEP_STD);
    assign seq  = pc_i + step;
    assign btgt = pc_i + imm_i;
    assign jtgt = (rs1_i + imm_i) & ~{{(XLEN-1){1'b0}}, 1'b1};

    // The instruction right behind a redirect is on the wrong path
    assign shadow   = redirect_o;
    assign acc      = id_valid_i && !shadow && !flush_i && !stall_i && (state == ST_IDLE);
    assign start_ok = id_valid_i && is_mc_i && !shadow && !flush_i;

    branch_compare #(.XLEN(XLEN)) u_cmp (
        .br_op (br_op_i),
        .rs1   (rs1_i),
        .rs2   (rs2_i),
        .taken (taken)
    );

    assign br_mis   = (taken != pred_taken_i) || (taken && (pred_pc_i != btgt));
    assign jalr_mis = !(pred_taken_i && (pred_pc_i == jtgt));
    assign redir_n  = acc && ((is_branch_i && br_mis) || (is_jalr_i && jalr_mis));
    assign upd_n    = acc && (is_branch_i || is_jalr_i);
    assign rpc_n    = is_jalr_i ? jtgt : (taken ? btgt : seq);

    // Register redirect and predictor update as single-cycle pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
            upd_valid_o   <= 1'b0;
            upd_taken_o   <= 1'b0;
            upd_pc_o      <= '0;
            upd_target_o  <= '0;
        end else begin
            redirect_o    <= redir_n;
            redirect_pc_o <= redir_n ? rpc_n : '0;
            upd_valid_o   <= upd_n;
            upd_taken_o   <= upd_n && (is_jalr_i || taken);
            upd_pc_o      <= upd_n ? pc_i : '0;
            upd_target_o  <= upd_n ? (is_jalr_i ? jtgt : btgt) : '0;
        end
    end

    // Saturating statistics; they count on the same edge the pulses register
    always_ff @(posedge clk) begin
        if (reset) begin
            br_cnt_o      <= '0;
            mispred_cnt_o <= '0;
        end else begin
            if (upd_n && (br_cnt_o != '1))
                br_cnt_o <= br_cnt_o + CNT_W'(1);
            if (redir_n && (mispred_cnt_o != '1))
                mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    // Next state, handshake outputs and the value EX/MEM would load
    always_comb begin
        state_n     = state;
        mc_start_o  = 1'b0;
        mc_kill_o   = 1'b0;
        stall_req_o = 1'b0;
        mc_latch    = 1'b0;
        ld_valid    = 1'b0;
        ld_result   = '0;
        case (state)
            ST_IDLE: begin
                ld_valid  = acc && !is_mc_i;
                ld_result = ld_valid ? (is_jalr_i ? seq : alu_result_i) : '0;
                if (start_ok) begin
                    mc_start_o  = 1'b1;
                    stall_req_o = 1'b1;
                    state_n     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall_req_o = 1'b1;
                ld_valid    = mc_done_i;
                ld_result   = mc_done_i ? mc_result_i : '0;
                if (flush_i) begin
                    mc_kill_o = 1'b1;
                    state_n   = ST_IDLE;
                end else if (mc_done_i && !stall_i) begin
                    stall_req_o = 1'b0;
                    state_n     = ST_IDLE;
                end else if (mc_done_i) begin
                    mc_latch = 1'b1;
                    state_n  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                stall_req_o = 1'b1;
                ld_valid    = 1'b1;
                ld_result   = mc_hold_q;
                if (flush_i || !stall_i)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        // Reset abandons the operation silently; the unit resets too
        if (reset) begin
            mc_start_o  = 1'b0;
            mc_kill_o   = 1'b0;
            stall_req_o = 1'b0;
        end
    end

    // Capture a finished result that arrived under a downstream stall
    always_ff @(posedge clk) begin
        if (reset)         mc_hold_q <= '0;
        else if (mc_latch) mc_hold_q <= mc_result_i;
    end

    // EX/MEM register: flush beats stall beats load
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            valid_e_o  <= 1'b0;
            result_e_o <= '0;
        end else if (!stall_i) begin
            valid_e_o  <= ld_valid;
            result_e_o <= ld_result;
        end
    end

endmodule

// File: tb/tb_pipeline_exe_bru.sv
// Directed bench for pipeline_exe_bru: vector table for branch/jalr/ALU,
// hand sequences for squash, multi-cycle, hold, flush and reset.
module tb_pipeline_exe_bru;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            id_valid, is_branch, is_jalr, is_mc, is_compressed;
    logic [2:0]      br_op;
    logic [XLEN-1:0] pc, rs1, rs2, imm, alu_result, pred_pc, mc_result;
    logic            pred_taken, mc_done, stall, flush;
    logic            mc_start, mc_kill, stall_req, valid_e, redirect;
    logic            upd_valid, upd_taken;
    logic [XLEN-1:0] result_e, redirect_pc, upd_pc, upd_target;
    logic [CNT_W-1:0] br_cnt, mispred_cnt;

    int tests = 0;
    int fails = 0;
    int exp_br = 0;
    int exp_mis = 0;

    always #5 clk = ~clk;

    pipeline_exe_bru #(.XLEN(XLEN), .RVC_EN(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid_i(id_valid), .is_branch_i(is_branch), .is_jalr_i(is_jalr),
        .is_mc_i(is_mc), .is_compressed_i(is_compressed), .br_op_i(br_op),
        .pc_i(pc), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
        .alu_result_i(alu_result), .pred_taken_i(pred_taken), .pred_pc_i(pred_pc),
        .mc_done_i(mc_done), .mc_result_i(mc_result), .stall_i(stall), .flush_i(flush),
        .mc_start_o(mc_start), .mc_kill_o(mc_kill), .stall_req_o(stall_req),
        .valid_e_o(valid_e), .result_e_o(result_e),
        .redirect_o(redirect), .redirect_pc_o(redirect_pc),
        .upd_valid_o(upd_valid), .upd_taken_o(upd_taken),
        .upd_pc_o(upd_pc), .upd_target_o(upd_target),
        .br_cnt_o(br_cnt), .mispred_cnt_o(mispred_cnt)
    );

    typedef struct {
        logic        vld, br, jr, rvc;
        logic [2:0]  op;
        logic [31:0] pc, rs1, rs2, imm;
        logic        pt;
        logic [31:0] ppc, alu;
        logic        e_redir;
        logic [31:0] e_rpc;
        logic        e_upd, e_ut;
        logic [31:0] e_utgt;
        logic        e_vld;
        logic [31:0] e_res;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; is_branch = 0; is_jalr = 0; is_mc = 0; is_compressed = 0;
        br_op = 0; pc = 0; rs1 = 0; rs2 = 0; imm = 0; alu_result = 0;
        pred_taken = 0; pred_pc = 0; mc_done = 0; mc_result = 0; stall = 0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        id_valid = v.vld; is_branch = v.br; is_jalr = v.jr; is_compressed = v.rvc;
        br_op = v.op; pc = v.pc; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
        pred_taken = v.pt; pred_pc = v.ppc; alu_result = v.alu;
    endtask

    function automatic int sat(input int x);
        return (x >= 3) ? 3 : x;
    endfunction

    initial begin
        //          vld br jr rvc op      pc            rs1           rs2           imm       pt ppc          alu        | redir rpc          upd ut utgt        vld res
        vecs[0]  = '{1,1,0,0,3'b100,32'h100,       32'hFFFFFFFF,32'h1,       32'h20,   0,32'h0,      32'h11,   1,32'h120,      1,1,32'h120,      1,32'h11};
        vecs[1]  = '{1,1,0,1,3'b000,32'h100,       32'h5,       32'h5,       32'h20,   1,32'h120,    32'h22,   0,32'h0,        1,1,32'h120,      1,32'h22};
        vecs[2]  = '{1,1,0,1,3'b000,32'h100,       32'h5,       32'h6,       32'h20,   1,32'h120,    32'h33,   1,32'h102,      1,0,32'h120,      1,32'h33};
        vecs[3]  = '{1,0,1,0,3'b000,32'h400,       32'h2001,    32'h0,       32'h2,    1,32'h2002,   32'h44,   0,32'h0,        1,1,32'h2002,     1,32'h404};
        vecs[4]  = '{1,0,1,0,3'b000,32'h400,       32'h2001,    32'h0,       32'h2,    1,32'h2000,   32'h44,   1,32'h2002,     1,1,32'h2002,     1,32'h404};
        vecs[5]  = '{1,1,0,0,3'b110,32'h200,       32'hFFFFFFFF,32'h1,       32'h40,   0,32'h0,      32'h55,   0,32'h0,        1,0,32'h240,      1,32'h55};
        vecs[6]  = '{1,1,0,0,3'b101,32'h200,       32'hFFFFFFFF,32'h1,       32'h40,   1,32'h240,    32'h66,   1,32'h204,      1,0,32'h240,      1,32'h66};
        vecs[7]  = '{1,1,0,0,3'b001,32'h300,       32'h3,       32'h4,       32'h10,   1,32'h999,    32'h77,   1,32'h310,      1,1,32'h310,      1,32'h77};
        vecs[8]  = '{1,1,0,0,3'b111,32'h300,       32'h1,       32'hFFFFFFFF,32'h10,   0,32'h0,      32'h88,   0,32'h0,        1,0,32'h310,      1,32'h88};
        vecs[9]  = '{1,1,0,0,3'b010,32'h300,       32'h7,       32'h7,       32'h10,   1,32'h310,    32'h99,   1,32'h304,      1,0,32'h310,      1,32'h99};
        vecs[10] = '{1,1,0,0,3'b000,32'hFFFFFFF0,  32'h1,       32'h1,       32'h20,   0,32'h0,      32'hAA,   1,32'h10,       1,1,32'h10,       1,32'hAA};
        vecs[11] = '{1,0,0,0,3'b000,32'h600,       32'h0,       32'h0,       32'h0,    0,32'h0,      32'hDEAD, 0,32'h0,        0,0,32'h0,        1,32'hDEAD};
        vecs[12] = '{0,0,0,0,3'b000,32'h600,       32'h0,       32'h0,       32'h0,    0,32'h0,      32'hBEEF, 0,32'h0,        0,0,32'h0,        0,32'h0};
        vecs[13] = '{1,0,1,1,3'b000,32'h500,       32'h3000,    32'h0,       32'h0,    0,32'h0,      32'hBB,   1,32'h3000,     1,1,32'h3000,     1,32'h502};
        vecs[14] = '{1,1,0,0,3'b100,32'h100,       32'h1,       32'hFFFFFFFF,32'h20,   1,32'h120,    32'hCC,   1,32'h104,      1,0,32'h120,      1,32'hCC};

        idle();
        reset = 1;
        tick(); tick();
        chk("rst valid_e", 32'(valid_e), 0);
        chk("rst result_e", result_e, 0);
        chk("rst redirect", 32'(redirect), 0);
        chk("rst upd_valid", 32'(upd_valid), 0);
        chk("rst br_cnt", 32'(br_cnt), 0);
        chk("rst mispred_cnt", 32'(mispred_cnt), 0);
        chk("rst stall_req", 32'(stall_req), 0);
        reset = 0;

        // Table vectors, each followed by an idle cycle to clear the shadow
        for (int i = 0; i < 15; i++) begin
            apply(vecs[i]);
            tick();
            if (vecs[i].e_upd) exp_br = sat(exp_br + 1);
            if (vecs[i].e_redir) exp_mis = sat(exp_mis + 1);
            chk($sformatf("v%0d redirect", i), 32'(redirect), 32'(vecs[i].e_redir));
            if (vecs[i].e_redir) chk($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].e_rpc);
            chk($sformatf("v%0d upd_valid", i), 32'(upd_valid), 32'(vecs[i].e_upd));
            if (vecs[i].e_upd) begin
                chk($sformatf("v%0d upd_taken", i), 32'(upd_taken), 32'(vecs[i].e_ut));
                chk($sformatf("v%0d upd_target", i), upd_target, vecs[i].e_utgt);
                chk($sformatf("v%0d upd_pc", i), upd_pc, vecs[i].pc);
            end
            chk($sformatf("v%0d valid_e", i), 32'(valid_e), 32'(vecs[i].e_vld));
            if (vecs[i].e_vld) chk($sformatf("v%0d result_e", i), result_e, vecs[i].e_res);
            chk($sformatf("v%0d br_cnt", i), 32'(br_cnt), 32'(exp_br));
            chk($sformatf("v%0d mispred_cnt", i), 32'(mispred_cnt), 32'(exp_mis));
            idle();
            tick();
            chk($sformatf("v%0d redirect pulse", i), 32'(redirect), 0);
        end

        // Wrong-path instruction right after a redirect is squashed
        apply(vecs[0]);
        tick();
        chk("sq redirect", 32'(redirect), 1);
        idle();
        id_valid = 1; alu_result = 32'h1234;
        tick();
        chk("sq valid_e", 32'(valid_e), 0);
        chk("sq no back-to-back", 32'(redirect), 0);
        idle();
        tick();

        // Multi-cycle op, done on the third BUSY cycle
        id_valid = 1; is_mc = 1;
        #1;
        chk("mc start", 32'(mc_start), 1);
        chk("mc start stall_req", 32'(stall_req), 1);
        tick();
        idle();
        #1;
        chk("mc busy1 stall_req", 32'(stall_req), 1);
        chk("mc busy1 start", 32'(mc_start), 0);
        tick();
        chk("mc busy valid_e", 32'(valid_e), 0);
        chk("mc busy2 stall_req", 32'(stall_req), 1);
        tick();
        mc_done = 1; mc_result = 32'hCAFE_0001;
        #1;
        chk("mc done stall_req", 32'(stall_req), 0);
        tick();
        idle();
        chk("mc valid_e", 32'(valid_e), 1);
        chk("mc result_e", result_e, 32'hCAFE_0001);
        chk("mc idle stall_req", 32'(stall_req), 0);
        tick();

        // Done under a two-cycle downstream stall goes through HOLD
        id_valid = 1; is_mc = 1;
        tick();
        idle();
        tick();
        mc_done = 1; mc_result = 32'h0000_BEEF; stall = 1;
        tick();
        mc_done = 0; mc_result = 0;
        #1;
        chk("hold stall_req", 32'(stall_req), 1);
        tick();
        chk("hold valid_e held", 32'(valid_e), 0);
        stall = 0;
        #1;
        chk("hold release stall_req", 32'(stall_req), 1);
        tick();
        chk("hold valid_e", 32'(valid_e), 1);
        chk("hold result_e", result_e, 32'h0000_BEEF);
        chk("hold idle stall_req", 32'(stall_req), 0);
        tick();

        // Flush while BUSY kills the unit
        id_valid = 1; is_mc = 1;
        tick();
        idle();
        flush = 1; mc_done = 1; mc_result = 32'h5555;
        #1;
        chk("flush kill", 32'(mc_kill), 1);
        tick();
        idle();
        chk("flush valid_e", 32'(valid_e), 0);
        chk("flush stall_req", 32'(stall_req), 0);
        chk("flush kill clear", 32'(mc_kill), 0);
        tick();

        // Reset while BUSY: back to IDLE without a kill
        id_valid = 1; is_mc = 1;
        tick();
        idle();
        reset = 1;
        #1;
        chk("rstbusy kill", 32'(mc_kill), 0);
        tick();
        reset = 0;
        #1;
        chk("rstbusy stall_req", 32'(stall_req), 0);
        chk("rstbusy valid_e", 32'(valid_e), 0);
        chk("rstbusy mispred_cnt", 32'(mispred_cnt), 0);
        chk("rstbusy br_cnt", 32'(br_cnt), 0);
        chk("rstbusy start", 32'(mc_start), 0);
        tick();
        chk("rstbusy idle valid_e", 32'(valid_e), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
